pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard/flush sequencer for the 5-stage RISC-V pipeline. Drives the PC write enable, IF/ID write/flush,
//  ID/EX flush (bubble insert) and a global hold for ID/EX, EX/MEM and MEM/WB.
//  Resolves load-use hazards, taken-branch squashes and data-memory wait states, in fixed priority order.
//  Keeps saturating performance counters for stall, flush and hold activity.
// PARAMETERS
//  FLUSH_CYCLES  1   squash cycles per taken branch (>=1); cycles beyond the first run in state FLUSH
//  CNT_W         16  width of each performance counter
// PORTS
//  clk            in   1      pipeline clock, rising edge
//  reset_n        in   1      synchronous, active-low reset
//  id_rs1         in   5      rs1 field of instruction in IF/ID
//  id_rs2         in   5      rs2 field of instruction in IF/ID
//  id_uses_rs1    in   1      ID instruction reads rs1
//  id_uses_rs2    in   1      ID instruction reads rs2
//  ex_rd          in   5      rd held in ID/EX
//  ex_memread     in   1      memread held in ID/EX
//  branch_taken   in   1      taken branch resolved in EX/MEM (branch & zero)
//  dmem_busy      in   1      data memory not ready this cycle
//  cnt_clr        in   1      synchronous clear of performance counters
//  pc_write       out  1      PC register load enable
//  ifid_write     out  1      IF/ID load enable
//  ifid_flush     out  1      IF/ID zero-load
//  idex_flush     out  1      ID/EX zero-load (bubble)
//  pipe_hold      out  1      hold ID/EX, EX/MEM, MEM/WB
//  state          out  2      FSM state: 0=RUN, 1=FLUSH, 2=MEM_WAIT
//  stall_cnt      out  CNT_W  load-use bubbles inserted
//  flush_cnt      out  CNT_W  taken-branch events
//  hold_cnt       out  CNT_W  cycles with pipe_hold=1
// BEHAVIOUR
//  - State and counters are registered. Control outputs are combinational from state and current inputs,
//    so all control decisions take effect in the same cycle (zero latency).
//  - Reset (reset_n=0 at posedge): state=RUN, squash counter=0, all perf counters=0.
//  - While reset_n=0, outputs are forced: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pipe_hold=0.
//  - load_use = ex_memread & (ex_rd!=0) & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
//  - Priority in RUN: dmem_busy > branch_taken > load_use > normal.
//  - RUN, dmem_busy:
//      pipe_hold=1, pc_write=0, ifid_write=0, no flush; next=MEM_WAIT.
//  - RUN, branch_taken:
//      pc_write=1, ifid_flush=1, idex_flush=1; flush_cnt++.
//      FLUSH_CYCLES>1: sq_cnt<=FLUSH_CYCLES-1, next=FLUSH. Otherwise stay RUN.
//  - RUN, load_use:
//      pc_write=0, ifid_write=0, idex_flush=1; stall_cnt++; stay RUN.
//      The bubble clears ex_rd next cycle, so the stall lasts exactly 1 cycle.
//  - RUN, normal: pc_write=1, ifid_write=1, all else 0.
//  - FLUSH, !dmem_busy:
//      pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1; sq_cnt--; next=RUN when sq_cnt==1.
//      load_use and branch_taken are ignored, since the squashed slots are invalid.
//  - FLUSH, dmem_busy: outputs as MEM_WAIT; sq_cnt frozen; stay FLUSH.
//  - MEM_WAIT, dmem_busy: hold outputs as RUN/dmem_busy.
//  - MEM_WAIT, !dmem_busy: outputs and next state evaluated exactly as RUN in the same cycle.
//    A branch_taken held in EX/MEM during the wait is therefore acted on at release.
//  - hold_cnt++ every cycle with pipe_hold=1.
//  - Counters saturate at all-ones. cnt_clr has priority over increments, except reset.
//  - No combinational path from the counters to the control outputs.
// TESTING
//  1. Reset: hold reset_n=0 for 2 cycles -> ifid_flush=idex_flush=1, pc_write=0; after release state=0,
//     counters=0, pc_write=ifid_write=1.
//  2. Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> 1 cycle pc_write=0, ifid_write=0,
//     idex_flush=1, stall_cnt=1. Same with ex_rd=0 -> no stall.
//  3. Branch with FLUSH_CYCLES=3: branch_taken for 1 cycle -> ifid_flush=idex_flush=1 for 3 cycles,
//     state 0->1->1->0, flush_cnt=1.
//  4. dmem_busy high 4 cycles with branch_taken also high -> pipe_hold=1 for 4 cycles, hold_cnt=4;
//     the flush fires in the cycle dmem_busy drops.
//  5. Simultaneous load_use and branch_taken in RUN -> branch wins (pc_write=1, both flushes), stall_cnt unchanged.
//  6. Saturation with CNT_W=2: 5 load-use events -> stall_cnt=3; then cnt_clr=1 -> all counters 0 next cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flush sequencer for the 5-stage RISC-V pipeline.
// Resolves data-memory wait states, taken-branch squashes and load-use hazards in that
// priority order. Control outputs are combinational from the registered state and the
// current inputs, so every decision acts in the same cycle. Saturating performance
// counters record stall, flush and hold activity.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,   // squash cycles per taken branch, must be >= 1
    parameter int CNT_W        = 16   // width of each performance counter
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // Squash counter only has to hold FLUSH_CYCLES-1.
    localparam int SQ_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [SQ_W-1:0]  SQ_LOAD = SQ_W'(FLUSH_CYCLES - 1);
    localparam logic [SQ_W-1:0]  SQ_ONE  = SQ_W'(1);
    localparam logic [SQ_W-1:0]  SQ_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            r_state;
    logic [SQ_W-1:0]   r_sq_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic [CNT_W-1:0]  r_hold_cnt;

    state_t            w_next_state;
    logic [SQ_W-1:0]   w_sq_next;
    logic              w_load_use;
    logic              w_stall_inc;
    logic              w_flush_inc;
    logic              w_pc_write;
    logic              w_ifid_write;
    logic              w_ifid_flush;
    logic              w_idex_flush;
    logic              w_pipe_hold;

    // Load-use: the EX load writes a non-zero register that the ID instruction reads.
    assign w_load_use = ex_memread && (ex_rd != 5'd0) &&
                        ((id_uses_rs1 && (ex_rd == id_rs1)) ||
                         (id_uses_rs2 && (ex_rd == id_rs2)));

    // Control decode and next-state selection; outputs depend only on state and inputs.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        w_next_state = r_state;
        w_sq_next    = r_sq_cnt;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_pipe_hold  = 1'b0;

        case (r_state)
            ST_FLUSH: begin
                if (dmem_busy) begin
                    // Memory stall freezes the squash sequence where it is.
                    w_pipe_hold = 1'b1;
                end else begin
                    // Squashed slots are invalid, so hazards on them are ignored.
                    w_pc_write   = 1'b1;
                    w_ifid_write = 1'b1;
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                    w_sq_next    = r_sq_cnt - SQ_ONE;
                    if (r_sq_cnt == SQ_ONE) begin
                        w_next_state = ST_RUN;
                    end
                end
            end
            default: begin
                // RUN, MEM_WAIT (released or still waiting) and the unused encoding
                // share one decision tree; the unused encoding recovers to RUN.
                w_next_state = ST_RUN;
                if (dmem_busy) begin
                    w_pipe_hold  = 1'b1;
                    w_next_state = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    w_pc_write   = 1'b1;
                    w_ifid_write = 1'b1;
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                    w_flush_inc  = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_sq_next    = SQ_LOAD;
                        w_next_state = ST_FLUSH;
                    end
                end else if (w_load_use) begin
                    // One bubble is enough: it clears ex_rd for the next cycle.
                    w_idex_flush = 1'b1;
                    w_stall_inc  = 1'b1;
                end else begin
                    w_pc_write   = 1'b1;
                    w_ifid_write = 1'b1;
                end
            end
        endcase

        // While in reset, keep the front end frozen and the pipeline registers empty.
        if (!reset_n) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_pipe_hold  = 1'b0;
        end
    end

    // Sequencer state and squash counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            r_state  <= ST_RUN;
            r_sq_cnt <= SQ_ZERO;
        end else begin
            r_state  <= w_next_state;
            r_sq_cnt <= w_sq_next;
        end
    end

    // Saturating performance counters; clear wins over increment, reset wins over both.
    always_ff @(posedge clk) begin
        if (!reset_n || cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_hold_cnt  <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_flush_inc && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
            if (w_pipe_hold && (r_hold_cnt != CNT_MAX)) begin
                r_hold_cnt <= r_hold_cnt + CNT_ONE;
            end
        end
    end

    assign pc_write   = w_pc_write;
    assign ifid_write = w_ifid_write;
    assign ifid_flush = w_ifid_flush;
    assign idex_flush = w_idex_flush;
    assign pipe_hold  = w_pipe_hold;
    assign state      = r_state;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;
    assign hold_cnt   = r_hold_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl. Two instances share the stimulus:
// dut uses a 3-cycle branch squash with 16-bit counters, dut_sat uses a single-cycle
// squash with 2-bit counters to reach saturation quickly.
module tb_pipeline_hazard_ctrl;

    // Control vector order: {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}
    localparam logic [4:0] CTL_NORMAL = 5'b11000;
    localparam logic [4:0] CTL_STALL  = 5'b00010;
    localparam logic [4:0] CTL_SQUASH = 5'b11110;
    localparam logic [4:0] CTL_HOLD   = 5'b00001;
    localparam logic [4:0] CTL_RESET  = 5'b00110;

    logic        clk;
    logic        reset_n;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_memread;
    logic        branch_taken;
    logic        dmem_busy;
    logic        cnt_clr;

    logic        pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt, hold_cnt;

    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_pipe_hold;
    logic [1:0]  s_state;
    logic [1:0]  s_stall_cnt, s_flush_cnt, s_hold_cnt;

    logic [4:0]  ctl;
    logic [4:0]  s_ctl;
    assign ctl   = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold};
    assign s_ctl = {s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_pipe_hold};

    int n_checks = 0;
    int n_errors = 0;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread),
        .branch_taken(branch_taken), .dmem_busy(dmem_busy), .cnt_clr(cnt_clr),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pipe_hold(pipe_hold),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hold_cnt(hold_cnt)
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread),
        .branch_taken(branch_taken), .dmem_busy(dmem_busy), .cnt_clr(cnt_clr),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .pipe_hold(s_pipe_hold),
        .state(s_state), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .hold_cnt(s_hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_rs1       = 5'd0;
        id_rs2       = 5'd0;
        id_uses_rs1  = 1'b0;
        id_uses_rs2  = 1'b0;
        ex_rd        = 5'd0;
        ex_memread   = 1'b0;
        branch_taken = 1'b0;
        dmem_busy    = 1'b0;
        cnt_clr      = 1'b0;
    endtask

    // Load in EX writing x5, ID instruction reads x5 through rs2.
    task automatic set_load_use();
        id_rs1      = 5'd3;
        id_rs2      = 5'd5;
        id_uses_rs1 = 1'b1;
        id_uses_rs2 = 1'b1;
        ex_rd       = 5'd5;
        ex_memread  = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_idle();
        #1;
        n_checks++;
        if (ctl !== CTL_RESET) begin
            n_errors++;
            $display("FAIL reset_ctl_pre_edge: got %b expected %b", ctl, CTL_RESET);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (ctl !== CTL_RESET) begin
                n_errors++;
                $display("FAIL reset_ctl_cycle%0d: got %b expected %b", i, ctl, CTL_RESET);
            end
        end
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (ctl !== CTL_NORMAL) begin
            n_errors++;
            $display("FAIL reset_release_ctl: got %b expected %b", ctl, CTL_NORMAL);
        end
        tick();
        n_checks++;
        if (state !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_state: got %0d expected 0", state);
        end
        n_checks++;
        if ({stall_cnt, flush_cnt, hold_cnt} !== 48'd0) begin
            n_errors++;
            $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0",
                     stall_cnt, flush_cnt, hold_cnt);
        end
        n_checks++;
        if ({s_stall_cnt, s_flush_cnt, s_hold_cnt} !== 6'd0) begin
            n_errors++;
            $display("FAIL reset_sat_counters: got %0d/%0d/%0d expected 0/0/0",
                     s_stall_cnt, s_flush_cnt, s_hold_cnt);
        end
    endtask

    task automatic test_load_use();
        // Vector table: {memread, ex_rd, rs1, uses1, rs2, uses2} -> stall expected
        logic [17:0] vec [6];
        logic        exp_stall [6];
        logic [15:0] exp_cnt;
        vec[0] = {1'b1, 5'd5, 5'd3, 1'b1, 5'd5, 1'b1}; exp_stall[0] = 1'b1; // rs2 match
        vec[1] = {1'b0, 5'd0, 5'd3, 1'b1, 5'd5, 1'b1}; exp_stall[1] = 1'b0; // bubble in EX
        vec[2] = {1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1}; exp_stall[2] = 1'b0; // x0 never hazards
        vec[3] = {1'b1, 5'd7, 5'd7, 1'b1, 5'd2, 1'b1}; exp_stall[3] = 1'b1; // rs1 match
        vec[4] = {1'b1, 5'd7, 5'd7, 1'b0, 5'd2, 1'b1}; exp_stall[4] = 1'b0; // rs1 unused
        vec[5] = {1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1}; exp_stall[5] = 1'b0; // not a load
        exp_cnt = 16'd0;
        for (int i = 0; i < 6; i++) begin
            {ex_memread, ex_rd, id_rs1, id_uses_rs1, id_rs2, id_uses_rs2} = vec[i];
            #1;
            n_checks++;
            if (ctl !== (exp_stall[i] ? CTL_STALL : CTL_NORMAL)) begin
                n_errors++;
                $display("FAIL load_use_ctl_vec%0d: got %b expected %b", i, ctl,
                         exp_stall[i] ? CTL_STALL : CTL_NORMAL);
            end
            if (exp_stall[i]) exp_cnt++;
            tick();
            n_checks++;
            if (stall_cnt !== exp_cnt) begin
                n_errors++;
                $display("FAIL load_use_stall_cnt_vec%0d: got %0d expected %0d", i, stall_cnt, exp_cnt);
            end
        end
        n_checks++;
        if (state !== 2'd0) begin
            n_errors++;
            $display("FAIL load_use_state: got %0d expected 0", state);
        end
        set_idle();
    endtask

    task automatic test_branch();
        branch_taken = 1'b1;
        #1;
        n_checks++;
        if (ctl !== CTL_SQUASH) begin
            n_errors++;
            $display("FAIL branch_ctl_c0: got %b expected %b", ctl, CTL_SQUASH);
        end
        tick();
        branch_taken = 1'b0;
        n_checks++;
        if (state !== 2'd1) begin
            n_errors++;
            $display("FAIL branch_state_c0: got %0d expected 1", state);
        end
        n_checks++;
        if (flush_cnt !== 16'd1) begin
            n_errors++;
            $display("FAIL branch_flush_cnt: got %0d expected 1", flush_cnt);
        end
        n_checks++;
        if (s_state !== 2'd0) begin
            n_errors++;
            $display("FAIL branch_single_cycle_state: got %0d expected 0", s_state);
        end
        #1;
        n_checks++;
        if (ctl !== CTL_SQUASH) begin
            n_errors++;
            $display("FAIL branch_ctl_c1: got %b expected %b", ctl, CTL_SQUASH);
        end
        n_checks++;
        if (s_ctl !== CTL_NORMAL) begin
            n_errors++;
            $display("FAIL branch_single_cycle_ctl_c1: got %b expected %b", s_ctl, CTL_NORMAL);
        end
        tick();
        n_checks++;
        if (state !== 2'd1) begin
            n_errors++;
            $display("FAIL branch_state_c1: got %0d expected 1", state);
        end
        #1;
        n_checks++;
        if (ctl !== CTL_SQUASH) begin
            n_errors++;
            $display("FAIL branch_ctl_c2: got %b expected %b", ctl, CTL_SQUASH);
        end
        tick();
        n_checks++;
        if (state !== 2'd0) begin
            n_errors++;
            $display("FAIL branch_state_c2: got %0d expected 0", state);
        end
        #1;
        n_checks++;
        if (ctl !== CTL_NORMAL) begin
            n_errors++;
            $display("FAIL branch_ctl_after: got %b expected %b", ctl, CTL_NORMAL);
        end
        n_checks++;
        if ({flush_cnt, s_flush_cnt} !== {16'd1, 2'd1}) begin
            n_errors++;
            $display("FAIL branch_flush_cnt_final: got %0d/%0d expected 1/1", flush_cnt, s_flush_cnt);
        end
    endtask

    task automatic test_dmem_wait();
        dmem_busy    = 1'b1;
        branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (ctl !== CTL_HOLD) begin
                n_errors++;
                $display("FAIL dmem_hold_ctl_c%0d: got %b expected %b", i, ctl, CTL_HOLD);
            end
            tick();
            n_checks++;
            if (state !== 2'd2) begin
                n_errors++;
                $display("FAIL dmem_state_c%0d: got %0d expected 2", i, state);
            end
        end
        n_checks++;
        if (hold_cnt !== 16'd4) begin
            n_errors++;
            $display("FAIL dmem_hold_cnt: got %0d expected 4", hold_cnt);
        end
        n_checks++;
        if (s_hold_cnt !== 2'd3) begin
            n_errors++;
            $display("FAIL dmem_hold_cnt_saturated: got %0d expected 3", s_hold_cnt);
        end
        n_checks++;
        if (flush_cnt !== 16'd1) begin
            n_errors++;
            $display("FAIL dmem_no_flush_while_busy: got %0d expected 1", flush_cnt);
        end
        // Release: the branch held in EX/MEM is acted on in this same cycle.
        dmem_busy = 1'b0;
        #1;
        n_checks++;
        if (ctl !== CTL_SQUASH) begin
            n_errors++;
            $display("FAIL dmem_release_ctl: got %b expected %b", ctl, CTL_SQUASH);
        end
        tick();
        branch_taken = 1'b0;
        n_checks++;
        if ({state, flush_cnt, hold_cnt} !== {2'd1, 16'd2, 16'd4}) begin
            n_errors++;
            $display("FAIL dmem_release_regs: got state=%0d flush=%0d hold=%0d expected 1/2/4",
                     state, flush_cnt, hold_cnt);
        end
        tick();
        tick();
        n_checks++;
        if (state !== 2'd0) begin
            n_errors++;
            $display("FAIL dmem_flush_done_state: got %0d expected 0", state);
        end
    endtask

    task automatic test_back_to_back();
        // Load-use and taken branch together in RUN: the branch wins.
        set_load_use();
        branch_taken = 1'b1;
        #1;
        n_checks++;
        if (ctl !== CTL_SQUASH) begin
            n_errors++;
            $display("FAIL priority_ctl: got %b expected %b", ctl, CTL_SQUASH);
        end
        tick();
        branch_taken = 1'b0;
        n_checks++;
        if ({state, stall_cnt, flush_cnt} !== {2'd1, 16'd2, 16'd3}) begin
            n_errors++;
            $display("FAIL priority_regs: got state=%0d stall=%0d flush=%0d expected 1/2/3",
                     state, stall_cnt, flush_cnt);
        end
        // Memory wait inside FLUSH freezes the squash sequence.
        dmem_busy = 1'b1;
        #1;
        n_checks++;
        if (ctl !== CTL_HOLD) begin
            n_errors++;
            $display("FAIL flush_busy_ctl: got %b expected %b", ctl, CTL_HOLD);
        end
        tick();
        dmem_busy = 1'b0;
        n_checks++;
        if ({state, hold_cnt} !== {2'd1, 16'd5}) begin
            n_errors++;
            $display("FAIL flush_busy_regs: got state=%0d hold=%0d expected 1/5", state, hold_cnt);
        end
        // Remaining two squash cycles ignore the still-present load-use hazard.
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (ctl !== CTL_SQUASH) begin
                n_errors++;
                $display("FAIL flush_ignores_load_use_c%0d: got %b expected %b", i, ctl, CTL_SQUASH);
            end
            tick();
        end
        n_checks++;
        if ({state, stall_cnt} !== {2'd0, 16'd2}) begin
            n_errors++;
            $display("FAIL flush_end_regs: got state=%0d stall=%0d expected 0/2", state, stall_cnt);
        end
        set_idle();
        tick();
    endtask

    task automatic test_saturation();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_checks++;
        if ({stall_cnt, flush_cnt, hold_cnt, s_stall_cnt, s_flush_cnt, s_hold_cnt} !== 54'd0) begin
            n_errors++;
            $display("FAIL clear_before_sat: got %0d/%0d/%0d sat %0d/%0d/%0d expected all 0",
                     stall_cnt, flush_cnt, hold_cnt, s_stall_cnt, s_flush_cnt, s_hold_cnt);
        end
        set_load_use();
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 2) begin
                n_checks++;
                if (s_stall_cnt !== 2'd3) begin
                    n_errors++;
                    $display("FAIL sat_reach_max: got %0d expected 3", s_stall_cnt);
                end
            end
        end
        n_checks++;
        if (s_stall_cnt !== 2'd3) begin
            n_errors++;
            $display("FAIL sat_stall_cnt: got %0d expected 3", s_stall_cnt);
        end
        n_checks++;
        if (stall_cnt !== 16'd5) begin
            n_errors++;
            $display("FAIL wide_stall_cnt: got %0d expected 5", stall_cnt);
        end
        // Clear wins over a simultaneous increment.
        cnt_clr = 1'b1;
        #1;
        n_checks++;
        if (ctl !== CTL_STALL) begin
            n_errors++;
            $display("FAIL clear_cycle_ctl: got %b expected %b", ctl, CTL_STALL);
        end
        tick();
        n_checks++;
        if ({stall_cnt, flush_cnt, hold_cnt, s_stall_cnt, s_flush_cnt, s_hold_cnt} !== 54'd0) begin
            n_errors++;
            $display("FAIL clear_priority: got %0d/%0d/%0d sat %0d/%0d/%0d expected all 0",
                     stall_cnt, flush_cnt, hold_cnt, s_stall_cnt, s_flush_cnt, s_hold_cnt);
        end
        set_idle();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_dmem_wait();
        test_back_to_back();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
